fir_sample_feeder: RTL and testbench

Upstream AXI-stream master that feeds 24-bit signed samples into the FIR filter wrapper's data slave port. It captures samples from a strobed source (ADC or NCO front end) into a small FIFO and presents them on a registered valid/data output held until the filter accepts them. Overflow is detected and counted, so dropped samples are visible to control logic rather than silently lost.

---
 rtl/fir_sample_feeder.sv | 137 +++++++++++++
 tb/tb_fir_sample_feeder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder
//   Captures strobed samples from an ADC/NCO front end into a small FIFO.
//   It then presents them to the FIR filter's AXI-stream data slave through a
//   registered valid/data stage. That stage is held stable until the filter
//   accepts it.
//   Dropped samples are never silent: each one sets a sticky flag and bumps a
//   saturating counter.
//
// Ports
//   sys_clk, sys_rst      clock; asynchronous active-high reset
//   sample_in             source sample (two's complement), qualified by sample_strobe
//   sample_strobe         one-cycle write request
//   enable                1 accepts strobes; 0 ignores them. The queue keeps draining.
//   clear_stats           synchronous clear of overflow/drop_count; wins over a drop
//   m_tdata, m_tvalid     output register toward the filter
//   m_tready              filter ready; it only feeds next-state logic
//   fifo_level            FIFO occupancy 0..FIFO_DEPTH, not counting the output register
//   overflow              sticky drop flag
//   drop_count            dropped-sample count, saturating at 0xFFFF
//
// Build option
//   FIR_FEEDER_TEST_RAMP_EN adds input test_mode and a ramp counter.
//   With test_mode=1, accepted writes store the counter instead of sample_in.
//   The counter advances on every accepted write.

module fir_sample_feeder #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_strobe,
  input  logic              enable,
  input  logic              clear_stats,
`ifdef FIR_FEEDER_TEST_RAMP_EN
  input  logic              test_mode,
`endif
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow,
  output logic [15:0]       drop_count
);

  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level;
  logic              out_full;

  logic              wr_req;
  logic              wr_acc;
  logic              drop;
  logic              pop;
  logic [DATA_W-1:0] wr_data;

  // Fullness and emptiness are judged on the pre-edge level. A full FIFO
  // therefore drops a write even when a pop happens in the same cycle.
  assign wr_req = sample_strobe & enable;
  assign wr_acc = wr_req & (level != LVL_FULL);
  assign drop   = wr_req & (level == LVL_FULL);

  // The output register reloads whenever it is empty or being consumed. This
  // keeps back-to-back transfers bubble-free. m_tready reaches only this
  // next-state term, never an output.
  assign pop    = (level != '0) & (~out_full | m_tready);

`ifdef FIR_FEEDER_TEST_RAMP_EN
  logic [DATA_W-1:0] ramp_cnt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      ramp_cnt <= '0;
    else if (wr_acc)
      ramp_cnt <= ramp_cnt + DATA_W'(1);
  end

  assign wr_data = test_mode ? ramp_cnt : sample_in;
`else
  assign wr_data = sample_in;
`endif

  // Storage needs no reset: the pointers and level define which entries are live.
  always_ff @(posedge sys_clk) begin
    if (wr_acc)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      out_full   <= 1'b0;
      m_tdata    <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;

      if (wr_acc && !pop)
        level <= level + LVL_ONE;
      else if (!wr_acc && pop)
        level <= level - LVL_ONE;

      if (pop) begin
        m_tdata  <= mem[rd_ptr];
        out_full <= 1'b1;
      end else if (out_full && m_tready) begin
        out_full <= 1'b0;
      end

      if (clear_stats) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF)
          drop_count <= drop_count + 16'd1;
      end
    end
  end

  assign m_tvalid   = out_full;
  assign fifo_level = level;

endmodule

// File: tb/tb_fir_sample_feeder.sv
module tb_fir_sample_feeder;

  localparam int DW    = 24;
  localparam int DEPTH = 16;

  logic          sys_clk;
  logic          sys_rst;
  logic [DW-1:0] sample_in;
  logic          sample_strobe;
  logic          enable;
  logic          clear_stats;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [4:0]    fifo_level;
  logic          overflow;
  logic [15:0]   drop_count;
`ifdef FIR_FEEDER_TEST_RAMP_EN
  logic          test_mode;
`endif

  int checks   = 0;
  int failures = 0;
  bit do_check = 1;

  // Reference model: a queue of stored samples plus one output slot.
  logic [DW-1:0] q[$];
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_drops;
  logic          m_ovf;
  logic [DW-1:0] m_ramp;

  fir_sample_feeder #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .ADDR_W(4)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .sample_in     (sample_in),
    .sample_strobe (sample_strobe),
    .enable        (enable),
    .clear_stats   (clear_stats),
`ifdef FIR_FEEDER_TEST_RAMP_EN
    .test_mode     (test_mode),
`endif
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .fifo_level    (fifo_level),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".tvalid"}, 32'(m_tvalid), 32'(m_valid));
    chk({tag, ".tdata"},  32'(m_tdata),  32'(m_data));
    chk({tag, ".level"},  32'(fifo_level), 32'(q.size()));
    chk({tag, ".ovf"},    32'(overflow), 32'(m_ovf));
    chk({tag, ".drops"},  32'(drop_count), 32'(m_drops));
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_drops = 0;
    m_ovf   = 1'b0;
    m_ramp  = '0;
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, then check 1 time unit later.
  task automatic cyc(input bit stb, input logic [DW-1:0] d, input bit en,
                     input bit rdy, input bit clr, input string tag);
    bit full, wr, ld;
    logic [DW-1:0] v;
    sample_strobe = stb;
    sample_in     = d;
    enable        = en;
    m_tready      = rdy;
    clear_stats   = clr;
    @(posedge sys_clk);
    full = (q.size() >= DEPTH);
    wr   = stb && en;
    ld   = (q.size() > 0) && (!m_valid || rdy);
    v    = d;
`ifdef FIR_FEEDER_TEST_RAMP_EN
    if (test_mode) v = m_ramp;
`endif
    if (ld) begin
      m_data  = q.pop_front();
      m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (wr && !full) begin
      q.push_back(v);
      m_ramp = m_ramp + 24'd1;
    end
    if (clr) begin
      m_drops = 0;
      m_ovf   = 1'b0;
    end else if (wr && full) begin
      m_ovf = 1'b1;
      if (m_drops < 65535) m_drops++;
    end
    #1;
    if (do_check) check_model(tag);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    sample_strobe = 0; enable = 0; m_tready = 0; clear_stats = 0; sample_in = '0;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    model_reset();
    check_model("reset");
  endtask

  initial begin
    sys_rst = 1'b1;
    sample_in = '0; sample_strobe = 0; enable = 0; clear_stats = 0; m_tready = 0;
`ifdef FIR_FEEDER_TEST_RAMP_EN
    test_mode = 1'b0;
`endif
    model_reset();
    #2;
    chk("rst.tvalid", 32'(m_tvalid), 32'd0);
    chk("rst.level",  32'(fifo_level), 32'd0);
    do_reset();

    // Single sample, 2-edge latency
    cyc(1, 24'h7FFFFF, 1, 1, 0, "single0");
    chk("single.lvl1",   32'(fifo_level), 32'd1);
    chk("single.nvalid", 32'(m_tvalid), 32'd0);
    cyc(0, 24'h0, 1, 1, 0, "single1");
    chk("single.valid",  32'(m_tvalid), 32'd1);
    chk("single.data",   32'(m_tdata), 32'h7FFFFF);
    cyc(0, 24'h0, 1, 1, 0, "single2");
    chk("single.done",   32'(m_tvalid), 32'd0);

    // Back-pressure: 20 strobes, ready low
    for (int i = 1; i <= 20; i++) cyc(1, DW'(i), 1, 0, 0, "bp_fill");
    chk("bp.hold",  32'(m_tdata), 32'd1);
    chk("bp.level", 32'(fifo_level), 32'd16);
    chk("bp.drops", 32'(drop_count), 32'd3);
    chk("bp.ovf",   32'(overflow), 32'd1);
    for (int i = 1; i <= 17; i++) begin
      chk("bp.out_valid", 32'(m_tvalid), 32'd1);
      chk("bp.out_data",  32'(m_tdata), 32'(i));
      cyc(0, '0, 1, 1, 0, "bp_drain");
    end
    chk("bp.empty", 32'(m_tvalid), 32'd0);

    // Full FIFO with simultaneous pop: the write is still dropped
    for (int i = 0; i < 17; i++) cyc(1, DW'(100 + i), 1, 0, 0, "full_fill");
    chk("full.level", 32'(fifo_level), 32'd16);
    cyc(1, 24'hABCDEF, 1, 1, 0, "full_rd");
    chk("full_rd.level", 32'(fifo_level), 32'd15);
    chk("full_rd.drops", 32'(drop_count), 32'd4);

    // Clear coincident with drop
    cyc(1, 24'h111111, 1, 0, 0, "refill");
    cyc(1, 24'h222222, 1, 0, 1, "clr_drop");
    chk("clr.drops", 32'(drop_count), 32'd0);
    chk("clr.ovf",   32'(overflow), 32'd0);

    // Saturation
    do_check = 0;
    for (int i = 0; i < 65540; i++) cyc(1, DW'(i), 1, 0, 0, "sat");
    do_check = 1;
    check_model("sat_end");
    chk("sat.drops", 32'(drop_count), 32'hFFFF);
    cyc(0, '0, 1, 0, 1, "sat_clr");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) != 0, DW'($urandom), ($urandom % 8) != 0,
          $urandom % 2 == 1, ($urandom % 32) == 0, "rand");

    // Reset mid-stream
    do_reset();
    for (int i = 1; i <= 6; i++) cyc(1, DW'(i * 3), 1, 0, 0, "mid_fill");
    chk("mid.level", 32'(fifo_level), 32'd5);
    chk("mid.valid", 32'(m_tvalid), 32'd1);
    #3;
    sys_rst = 1'b1;
    #1;
    chk("async.valid", 32'(m_tvalid), 32'd0);
    chk("async.data",  32'(m_tdata), 32'd0);
    chk("async.level", 32'(fifo_level), 32'd0);
    chk("async.ovf",   32'(overflow), 32'd0);
    chk("async.drops", 32'(drop_count), 32'd0);
    model_reset();
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    cyc(1, 24'h123456, 1, 1, 0, "post0");
    chk("post.lvl1",   32'(fifo_level), 32'd1);
    chk("post.nvalid", 32'(m_tvalid), 32'd0);
    cyc(0, '0, 1, 1, 0, "post1");
    chk("post.valid", 32'(m_tvalid), 32'd1);
    chk("post.data",  32'(m_tdata), 32'h123456);

`ifdef FIR_FEEDER_TEST_RAMP_EN
    do_reset();
    test_mode = 1'b1;
    for (int i = 0; i < 20; i++) cyc(1, 24'hFFFFFF, 1, 0, 0, "ramp_fill");
    for (int i = 0; i < 20; i++) cyc(0, '0, 1, 1, 0, "ramp_drain");
    cyc(1, 24'hFFFFFF, 1, 1, 0, "ramp_resume");
    cyc(0, '0, 1, 1, 0, "ramp_out");
    chk("ramp.resume", 32'(m_tdata), 32'd17);
    test_mode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
